// File: rtl/vec_issue_queue.sv
// In-order issue buffer between the X-IF issue/commit channels and the vector core.
// Entries wait for commit or kill, then leave strictly in issue order.
module vec_issue_queue #(
    parameter int DEPTH      = 4,
    parameter int X_ID_WIDTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          issue_valid_i,
    output logic                          issue_ready_o,
    input  logic [31:0]                   issue_instr_i,
    input  logic [X_ID_WIDTH-1:0]         issue_id_i,
    input  logic [31:0]                   issue_rs1_i,
    output logic                          issue_accept_o,
    output logic                          issue_loadstore_o,
    input  logic                          commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]         commit_id_i,
    input  logic                          commit_kill_i,
    output logic                          dispatch_valid_o,
    input  logic                          dispatch_ready_i,
    output logic [31:0]                   dispatch_instr_o,
    output logic [X_ID_WIDTH-1:0]         dispatch_id_o,
    output logic [31:0]                   dispatch_rs1_o,
    output logic [$clog2(DEPTH+1)-1:0]    count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    localparam logic [6:0] CUSTOM0_OPCODE = 7'h0B;
    localparam logic [6:0] F_VLD   = 7'h00;
    localparam logic [6:0] F_VST   = 7'h01;
    localparam logic [6:0] F_VADD  = 7'h02;
    localparam logic [6:0] F_VSUB  = 7'h03;
    localparam logic [6:0] F_VMUL  = 7'h04;
    localparam logic [6:0] F_VMAC  = 7'h05;
    localparam logic [6:0] F_VMMUL = 7'h06;

    logic [31:0]           r_instr [DEPTH];
    logic [X_ID_WIDTH-1:0] r_id    [DEPTH];
    logic [31:0]           r_rs1   [DEPTH];
    logic [DEPTH-1:0]      r_valid;
    logic [DEPTH-1:0]      r_committed;
    logic [DEPTH-1:0]      r_killed;
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;

    logic       w_funct_ok;
    logic       w_funct_ls;
    logic       w_supported;
    logic       w_push;
    logic       w_commit_new;
    logic       w_head_live;
    logic       w_pop;
    logic       w_drop;
    logic       w_leave;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_funct_ok = 1'b0;
        w_funct_ls = 1'b0;
        case (issue_instr_i[31:25])
            F_VLD, F_VST: begin
                w_funct_ok = 1'b1;
                w_funct_ls = 1'b1;
            end
            F_VADD, F_VSUB, F_VMUL, F_VMAC, F_VMMUL: w_funct_ok = 1'b1;
            default: ;
        endcase
    end

    assign w_supported       = (issue_instr_i[6:0] == CUSTOM0_OPCODE) && w_funct_ok;
    assign issue_accept_o    = w_supported;
    assign issue_loadstore_o = w_supported && w_funct_ls;

    // Readiness depends only on occupancy: a full queue never passes an issue through.
    assign issue_ready_o = (r_count < FULL_COUNT);
    assign w_push        = issue_valid_i && issue_ready_o && w_supported;
    assign w_commit_new  = commit_valid_i && (commit_id_i == issue_id_i);

    assign w_head_live      = r_valid[r_rptr];
    assign dispatch_valid_o = w_head_live && r_committed[r_rptr] && !r_killed[r_rptr];
    assign dispatch_instr_o = r_instr[r_rptr];
    assign dispatch_id_o    = r_id[r_rptr];
    assign dispatch_rs1_o   = r_rs1[r_rptr];
    assign w_pop            = dispatch_valid_o && dispatch_ready_i;
    assign w_drop           = w_head_live && r_killed[r_rptr];
    assign w_leave          = w_pop || w_drop;
    assign count_o          = r_count;

    // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid     <= '0;
            r_committed <= '0;
            r_killed    <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (commit_valid_i && r_valid[i] && (r_id[i] == commit_id_i)) begin
                    r_committed[i] <= 1'b1;
                    if (commit_kill_i) begin
                        r_killed[i] <= 1'b1;
                    end
                end
            end

            if (w_leave) begin
                r_valid[r_rptr] <= 1'b0;
                r_rptr          <= r_rptr + PW'(1);
            end

            // The write slot is always free here, so this never collides with the leave above.
            if (w_push) begin
                r_valid[r_wptr]     <= 1'b1;
                r_committed[r_wptr] <= w_commit_new;
                r_killed[r_wptr]    <= w_commit_new && commit_kill_i;
                r_wptr              <= r_wptr + PW'(1);
            end

            case ({w_push, w_leave})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
        end
    end

    // NOTE: payload storage is not reset; the valid flags alone decide what is live.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_instr[r_wptr] <= issue_instr_i;
            r_id[r_wptr]    <= issue_id_i;
            r_rs1[r_wptr]   <= issue_rs1_i;
        end
    end

endmodule

// File: doc/vec_issue_queue.md
Name: vec_issue_queue

Overview:
- In-order instruction buffer between the CPU's X-IF issue/commit channels and the vector coprocessor control FSM.
- Decodes each offered instruction, accepts CUSTOM0 vector ops and stores them with ID and rs1 value.
- Holds each entry until the CPU commits or kills it, then presents committed entries one at a time to the coprocessor core.
- Lets the CPU issue ahead while the core is busy with a long VMMUL/VLD.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
X_ID_WIDTH, 4, width of X-IF instruction ID

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
issue_valid_i  input  1  CPU offers an instruction
issue_ready_o  output  1  queue can take an offer this cycle
issue_instr_i  input  32  raw instruction word
issue_id_i  input  X_ID_WIDTH  X-IF instruction ID
issue_rs1_i  input  32  scalar rs1 operand value
issue_accept_o  output  1  offered instruction is a supported vector op (combinational)
issue_loadstore_o  output  1  accepted op is VLD/VST (combinational)
commit_valid_i  input  1  commit/kill event
commit_id_i  input  X_ID_WIDTH  ID being committed/killed
commit_kill_i  input  1  1 = kill, 0 = commit
dispatch_valid_o  output  1  head entry ready for the core
dispatch_ready_i  input  1  core takes head entry
dispatch_instr_o  output  32  head instruction word
dispatch_id_o  output  X_ID_WIDTH  head ID
dispatch_rs1_o  output  32  head rs1 value
count_o  output  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (rst_i high at a clock edge): all entries invalid; read and write pointers 0; count_o = 0; dispatch_valid_o = 0; issue_ready_o = 1 from the next cycle. Reset overrides every same-cycle event. Entries in flight at reset are discarded and never dispatched.
- Decode: supported = opcode[6:0] == CUSTOM0_OPCODE and funct7 in {VLD, VST, VADD, VSUB, VMUL, VMAC, VMMUL}, using the custom_opcodes.vh values.
  - issue_accept_o = supported. issue_loadstore_o = supported and funct7 in {VLD, VST}.
  - Both outputs are valid whenever issue_valid_i = 1.
- Issue handshake: a transfer happens when issue_valid_i && issue_ready_o.
  - issue_ready_o = (count_o < DEPTH). It does not depend on dispatch_ready_i, so there is no pass-through when full.
  - An unsupported transfer completes with accept = 0 and is not stored.
  - A supported transfer writes {instr, id, rs1, committed = 0, killed = 0} at the write pointer. The write pointer increments mod DEPTH.
- Commit: when commit_valid_i = 1, every valid entry with id == commit_id_i gets committed = 1, and killed = 1 if commit_kill_i = 1.
  - An entry written in the same cycle with the matching ID also receives the commit.
  - A commit to an ID not in the queue is ignored.
  - Committed/killed flags are sticky until the entry leaves.
- Head processing:
  - Head valid, committed, not killed: dispatch_valid_o = 1 and dispatch_* show the head fields (combinational from storage).
  - Pop on dispatch_valid_o && dispatch_ready_i.
  - Head killed: dropped at the next edge with dispatch_valid_o = 0. At most one drop or pop per cycle.
  - Head not yet committed: dispatch_valid_o = 0 and the queue waits. Younger committed entries never bypass it (strict in-order).
- Latency: with an empty queue, issue at edge N plus commit in the same cycle gives dispatch_valid_o = 1 in the cycle after edge N. With commit one cycle later, dispatch follows one cycle after the commit.
- count_o:
  - +1 on a supported issue transfer.
  - -1 on a pop or drop.
  - Unchanged when both happen in the same cycle (allowed whenever count_o < DEPTH).
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are derived from count_o, not from pointer equality.
- dispatch_* hold stable while dispatch_valid_o = 1 and dispatch_ready_i = 0.

Test Plan:
1. Assert rst_i 2 cycles -> count_o = 0, dispatch_valid_o = 0, issue_ready_o = 1; issue VADD id 3 during reset -> not stored.
2. Issue VADD (opcode 0x0B) id 3, rs1 0x1000; commit id 3 kill 0 next cycle; dispatch_ready_i = 0 for 3 cycles, then 1 -> dispatch_valid_o high from the cycle after the commit, id 3, rs1 0x1000 stable; pop; count_o 1 -> 0.
3. DEPTH = 4: issue ids 1, 2, 3, 4 without commit -> issue_ready_o = 0, count_o = 4; commit ids 4, 3, 2 -> dispatch_valid_o stays 0; commit 1 -> dispatch order 1, 2, 3, 4.
4. Issue ids 5, 6; kill 5, commit 6 -> id 5 dropped with dispatch_valid_o never high for it; id 6 dispatched; count_o ends at 0.
5. Offer opcode 0x33 (OP) id 7 -> issue_accept_o = 0 in the same cycle, count_o unchanged; offer VLD -> accept = 1, loadstore = 1.
6. Queue holds 3 committed entries while a pop and a new issue occur in the same cycle -> count_o stays 3; run 10 entries to exercise pointer wrap, FIFO order intact; assert rst_i mid-stream -> queue empty next cycle.
